// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared lane geometry helpers and default stream widths
package bus_pkg;

    localparam int DEFAULT_IN_WIDTH = 8;
    localparam int DEFAULT_RATIO    = 4;

    function automatic int lane_idx_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    function automatic int lane_offset(input int lane, input int in_width);
        return lane * in_width;
    endfunction

endpackage

// File: rtl/bus_pack_upsize_if.sv
// rtl/bus_pack_upsize_if.sv - narrow-in / wide-out valid-ready stream bundle
import bus_pkg::*;

interface bus_pack_upsize_if #(
    parameter int IN_WIDTH = DEFAULT_IN_WIDTH,
    parameter int RATIO    = DEFAULT_RATIO
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;

    logic                 valid_i;
    logic                 ready_o;
    logic [IN_WIDTH-1:0]  data_i;
    logic                 last_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [OUT_WIDTH-1:0] data_o;
    logic [RATIO-1:0]     keep_o;
    logic                 last_o;

    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, keep_o, last_o
    );

    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, keep_o, last_o
    );
endinterface

// File: rtl/bus_pack_out_reg.sv
// rtl/bus_pack_out_reg.sv - registered output word with load-on-complete and clear-on-fire
import bus_pkg::*;

module bus_pack_out_reg #(
    parameter int IN_WIDTH = DEFAULT_IN_WIDTH,
    parameter int RATIO    = DEFAULT_RATIO
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [IN_WIDTH*RATIO-1:0]    load_data,
    input  logic [RATIO-1:0]             load_keep,
    input  logic                         load_last,
    input  logic                         ready_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [IN_WIDTH*RATIO-1:0]    data_o,
    output logic [RATIO-1:0]             keep_o,
    output logic                         last_o
);
    // A load only happens on an accepted beat, so it never overwrites an unconsumed word.
    assign ready_o = ~valid_o | ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            keep_o  <= '0;
            last_o  <= 1'b0;
        end else if (load) begin
            valid_o <= 1'b1;
            data_o  <= load_data;
            keep_o  <= load_keep;
            last_o  <= load_last;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/bus_pack_upsize.sv
// rtl/bus_pack_upsize.sv - packs RATIO narrow beats into one wide word with lane keep
import bus_pkg::*;

module bus_pack_upsize #(
    parameter int IN_WIDTH = DEFAULT_IN_WIDTH,
    parameter int RATIO    = DEFAULT_RATIO
) (
    input  logic              clk,
    input  logic              rst,
    bus_pack_upsize_if.slave  bus
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CW        = lane_idx_width(RATIO);

    logic [CW-1:0]        cnt;
    logic [OUT_WIDTH-1:0] acc;
    logic [RATIO-1:0]     acc_keep;
    logic [OUT_WIDTH-1:0] merge_data;
    logic [RATIO-1:0]     merge_keep;
    logic                 in_fire;
    logic                 complete;

    assign in_fire  = bus.valid_i && bus.ready_o;
    assign complete = in_fire && ((cnt == CW'(RATIO - 1)) || bus.last_i);

    always_comb begin
        merge_data = acc;
        merge_data[lane_offset(int'(cnt), IN_WIDTH) +: IN_WIDTH] = bus.data_i;
        merge_keep = acc_keep | (RATIO'(1) << cnt);
    end

    // Clearing the accumulator on completion keeps unfilled lanes of short words at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            acc_keep <= '0;
        end else if (complete) begin
            cnt      <= '0;
            acc      <= '0;
            acc_keep <= '0;
        end else if (in_fire) begin
            cnt      <= cnt + CW'(1);
            acc      <= merge_data;
            acc_keep <= merge_keep;
        end
    end

    bus_pack_out_reg #(
        .IN_WIDTH (IN_WIDTH),
        .RATIO    (RATIO)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_data (merge_data),
        .load_keep (merge_keep),
        .load_last (bus.last_i),
        .ready_i   (bus.ready_i),
        .ready_o   (bus.ready_o),
        .valid_o   (bus.valid_o),
        .data_o    (bus.data_o),
        .keep_o    (bus.keep_o),
        .last_o    (bus.last_o)
    );

endmodule
